// File: rtl/shot_controller_if.sv
// Bus between the game logic and the projectile pool: frame pulse, keyboard,
// player position, collision clears, VGA scan position and pool status.
interface shot_controller_if #(
  parameter int NUM_SHOTS = 4
);
  logic                 frame_clk;
  logic [7:0]           keycode;
  logic [9:0]           player_x;
  logic [NUM_SHOTS-1:0] hit;
  logic [9:0]           DrawX;
  logic [9:0]           DrawY;
  logic                 is_shot;
  logic [NUM_SHOTS-1:0] shot_active;
  logic [7:0]           shots_fired;

  modport slave (
    input  frame_clk, keycode, player_x, hit, DrawX, DrawY,
    output is_shot, shot_active, shots_fired
  );

  modport master (
    output frame_clk, keycode, player_x, hit, DrawX, DrawY,
    input  is_shot, shot_active, shots_fired
  );
endinterface

// File: rtl/shot_controller.sv
// Projectile pool with fire cooldown, per-frame upward motion and pixel test.
// Define SHOT_AUTOFIRE_EN to let a held fire key relaunch after each cooldown.
module shot_controller #(
  parameter int         NUM_SHOTS       = 4,
  parameter logic [7:0] FIRE_KEY        = 8'd44,
  parameter logic [9:0] SHOT_Y_START    = 10'd432,
  parameter logic [9:0] SHOT_STEP       = 10'd4,
  parameter logic [9:0] SHOT_W          = 10'd2,
  parameter logic [9:0] SHOT_H          = 10'd6,
  parameter logic [3:0] COOLDOWN_FRAMES = 4'd8
) (
  input  logic              Clk,
  input  logic              Reset,
  shot_controller_if.slave  bus
);

  typedef enum logic [1:0] {READY, COOLDOWN, WAIT_RELEASE} state_t;

  state_t               state;
  logic [3:0]           cooldown;
  logic [7:0]           fired_cnt;
  logic [NUM_SHOTS-1:0] active;
  logic [9:0]           shot_x [NUM_SHOTS];
  logic [9:0]           shot_y [NUM_SHOTS];

  logic                 frame_clk_p0;
  logic                 frame_tick_p1;

  logic                 key_fire;
  logic                 expiring;
  logic                 fire_ok;
  logic                 fire;
  logic                 found;
  logic [NUM_SHOTS-1:0] launch_sel;
  logic                 launch;
  logic                 pix_hit;

  // True when pos lies in [base, base+len-1]; 11-bit math keeps the edge from wrapping.
  function automatic logic in_span(input logic [9:0] pos, input logic [9:0] base,
                                   input logic [9:0] len);
    return ({1'b0, pos} >= {1'b0, base}) && ({1'b0, pos} < ({1'b0, base} + {1'b0, len}));
  endfunction

  // Stage p0/p1: frame_clk history and rising-edge tick.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_clk_p0  <= 1'b0;
      frame_tick_p1 <= 1'b0;
    end else begin
      frame_clk_p0  <= bus.frame_clk;
      frame_tick_p1 <= bus.frame_clk & ~frame_clk_p0;
    end
  end

  // The tick on which the cooldown runs out counts as the first ready tick in autofire.
  always_comb begin
    key_fire = (bus.keycode == FIRE_KEY);
    expiring = (state == COOLDOWN) && (cooldown <= 4'd1);
`ifdef SHOT_AUTOFIRE_EN
    fire_ok  = (state == READY) || expiring;
`else
    fire_ok  = (state == READY);
`endif
    fire       = frame_tick_p1 && key_fire && fire_ok;
    found      = 1'b0;
    launch_sel = '0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (!found && !active[i] && !bus.hit[i]) begin
        launch_sel[i] = fire;
        found         = 1'b1;
      end
    end
    launch = |launch_sel;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= READY;
      cooldown  <= 4'd0;
      fired_cnt <= 8'd0;
    end else if (frame_tick_p1) begin
      if (launch) begin
        cooldown  <= COOLDOWN_FRAMES;
        fired_cnt <= fired_cnt + 8'd1;
        state     <= COOLDOWN;
      end else begin
        case (state)
          READY: state <= READY;
          COOLDOWN: begin
            if (expiring) begin
              cooldown <= 4'd0;
`ifdef SHOT_AUTOFIRE_EN
              state    <= READY;
`else
              state    <= key_fire ? WAIT_RELEASE : READY;
`endif
            end else begin
              cooldown <= cooldown - 4'd1;
            end
          end
          WAIT_RELEASE: if (!key_fire) state <= READY;
          default: state <= READY;
        endcase
      end
    end
  end

  // A hit wins over both launch and motion; slots about to underflow retire instead.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      active <= '0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
        shot_x[i] <= 10'd0;
        shot_y[i] <= 10'd0;
      end
    end else begin
      for (int i = 0; i < NUM_SHOTS; i++) begin
        if (bus.hit[i]) begin
          active[i] <= 1'b0;
        end else if (launch_sel[i]) begin
          active[i] <= 1'b1;
          shot_x[i] <= bus.player_x;
          shot_y[i] <= SHOT_Y_START;
        end else if (frame_tick_p1 && active[i]) begin
          if (shot_y[i] < SHOT_STEP) active[i] <= 1'b0;
          else                       shot_y[i] <= shot_y[i] - SHOT_STEP;
        end
      end
    end
  end

  always_comb begin
    pix_hit = 1'b0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (active[i] && in_span(bus.DrawX, shot_x[i], SHOT_W) &&
          in_span(bus.DrawY, shot_y[i], SHOT_H))
        pix_hit = 1'b1;
    end
  end

  assign bus.is_shot     = pix_hit;
  assign bus.shot_active = active;
  assign bus.shots_fired = fired_cnt;

endmodule

// File: tb/tb_shot_controller.sv
// Directed bench for shot_controller: launch, motion, cooldown, pool limits,
// hit clears, pixel hit-test, reset behaviour and launch-counter wrap.
module tb_shot_controller;
  logic Clk = 1'b0;
  logic Reset;
  logic [3:0] hit2;
  int n_pass = 0;
  int n_total = 0;

  always #5 Clk = ~Clk;

  shot_controller_if #(.NUM_SHOTS(4)) bus ();
  shot_controller_if #(.NUM_SHOTS(4)) bus2 ();

  shot_controller dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  shot_controller #(.SHOT_Y_START(10'd10)) dut2 (.Clk(Clk), .Reset(Reset), .bus(bus2));

  assign bus2.frame_clk = bus.frame_clk;
  assign bus2.keycode   = bus.keycode;
  assign bus2.player_x  = bus.player_x;
  assign bus2.DrawX     = bus.DrawX;
  assign bus2.DrawY     = bus.DrawY;
  assign bus2.hit       = hit2;

  task automatic do_frame();
    @(negedge Clk) bus.frame_clk = 1'b1;
    @(negedge Clk) bus.frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic do_frames(input int n);
    for (int k = 0; k < n; k++) do_frame();
  endtask

  task automatic frame_hit(input logic [3:0] hv);
    @(negedge Clk) bus.frame_clk = 1'b1;
    @(negedge Clk) begin bus.frame_clk = 1'b0; bus.hit = hv; end
    @(negedge Clk) bus.hit = 4'b0000;
    repeat (2) @(negedge Clk);
  endtask

  task automatic pulse_hit(input logic [3:0] hv);
    @(negedge Clk) bus.hit = hv;
    @(negedge Clk) bus.hit = 4'b0000;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.keycode = 8'd0;
    bus.hit = 4'b0000;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic launch_and_settle();
    bus.keycode = 8'd44;
    do_frame();
    bus.keycode = 8'd0;
    do_frames(8);
  endtask

  task automatic test_reset();
    do_reset();
    bus.DrawX = 10'd0; bus.DrawY = 10'd0; #1;
    n_total++; if (bus.shot_active !== 4'b0000) $display("FAIL reset_active got %b want 0000", bus.shot_active); else n_pass++;
    n_total++; if (bus.shots_fired !== 8'd0) $display("FAIL reset_fired got %0d want 0", bus.shots_fired); else n_pass++;
    n_total++; if (bus.is_shot !== 1'b0) $display("FAIL reset_is_shot got %b want 0", bus.is_shot); else n_pass++;
  endtask

  task automatic test_single_shot();
    do_reset();
    bus.player_x = 10'd100;
    bus.keycode = 8'd44;
    do_frame();
    bus.keycode = 8'd0;
    n_total++; if (bus.shot_active !== 4'b0001) $display("FAIL launch_active got %b want 0001", bus.shot_active); else n_pass++;
    n_total++; if (bus.shots_fired !== 8'd1) $display("FAIL launch_fired got %0d want 1", bus.shots_fired); else n_pass++;
    bus.DrawX = 10'd100; bus.DrawY = 10'd432; #1;
    n_total++; if (bus.is_shot !== 1'b1) $display("FAIL launch_pix_432 got %b want 1", bus.is_shot); else n_pass++;
    bus.DrawY = 10'd431; #1;
    n_total++; if (bus.is_shot !== 1'b0) $display("FAIL launch_pix_431 got %b want 0", bus.is_shot); else n_pass++;
    do_frames(2);
    bus.DrawX = 10'd100; bus.DrawY = 10'd2; #1;
    n_total++; if (bus2.is_shot !== 1'b1) $display("FAIL low_slot_y2 got %b want 1", bus2.is_shot); else n_pass++;
    do_frame();
    n_total++; if (bus2.shot_active !== 4'b0000) $display("FAIL low_slot_retire got %b want 0000", bus2.shot_active); else n_pass++;
    bus.DrawY = 10'd1022; #1;
    n_total++; if (bus2.is_shot !== 1'b0) $display("FAIL low_slot_nowrap got %b want 0", bus2.is_shot); else n_pass++;
    bus.DrawY = 10'd420; #1;
    n_total++; if (bus.is_shot !== 1'b1) $display("FAIL move_pix_420 got %b want 1", bus.is_shot); else n_pass++;
    bus.DrawY = 10'd419; #1;
    n_total++; if (bus.is_shot !== 1'b0) $display("FAIL move_pix_419 got %b want 0", bus.is_shot); else n_pass++;
    bus.DrawX = 10'd101; bus.DrawY = 10'd425; #1;
    n_total++; if (bus.is_shot !== 1'b1) $display("FAIL move_pix_corner got %b want 1", bus.is_shot); else n_pass++;
    bus.DrawY = 10'd426; #1;
    n_total++; if (bus.is_shot !== 1'b0) $display("FAIL move_pix_below got %b want 0", bus.is_shot); else n_pass++;
  endtask

`ifdef SHOT_AUTOFIRE_EN
  task automatic test_autofire();
    do_reset();
    bus.keycode = 8'd44;
    do_frame();
    n_total++; if (bus.shots_fired !== 8'd1) $display("FAIL auto_f0 got %0d want 1", bus.shots_fired); else n_pass++;
    do_frames(7);
    n_total++; if (bus.shots_fired !== 8'd1) $display("FAIL auto_f7 got %0d want 1", bus.shots_fired); else n_pass++;
    do_frame();
    n_total++; if (bus.shots_fired !== 8'd2) $display("FAIL auto_f8 got %0d want 2", bus.shots_fired); else n_pass++;
    do_frames(31);
    n_total++; if (bus.shots_fired !== 8'd4) $display("FAIL auto_f39 got %0d want 4", bus.shots_fired); else n_pass++;
    n_total++; if (bus.shot_active !== 4'b1111) $display("FAIL auto_active got %b want 1111", bus.shot_active); else n_pass++;
    bus.keycode = 8'd0;
  endtask
`else
  task automatic test_hold();
    do_reset();
    bus.keycode = 8'd44;
    do_frames(40);
    n_total++; if (bus.shots_fired !== 8'd1) $display("FAIL hold_fired got %0d want 1", bus.shots_fired); else n_pass++;
    n_total++; if (bus.shot_active !== 4'b0001) $display("FAIL hold_active got %b want 0001", bus.shot_active); else n_pass++;
    bus.keycode = 8'd0;
    do_frame();
    bus.keycode = 8'd44;
    do_frame();
    n_total++; if (bus.shots_fired !== 8'd2) $display("FAIL repress_fired got %0d want 2", bus.shots_fired); else n_pass++;
    n_total++; if (bus.shot_active !== 4'b0011) $display("FAIL repress_active got %b want 0011", bus.shot_active); else n_pass++;
    do_frames(3);
    n_total++; if (bus.shots_fired !== 8'd2) $display("FAIL cooldown_block got %0d want 2", bus.shots_fired); else n_pass++;
    bus.keycode = 8'd0;
  endtask
`endif

  task automatic test_hit_launch();
    do_reset();
    launch_and_settle();
    bus.keycode = 8'd44;
    frame_hit(4'b0001);
    bus.keycode = 8'd0;
    n_total++; if (bus.shot_active !== 4'b0010) $display("FAIL hit_launch_active got %b want 0010", bus.shot_active); else n_pass++;
    n_total++; if (bus.shots_fired !== 8'd2) $display("FAIL hit_launch_fired got %0d want 2", bus.shots_fired); else n_pass++;
    pulse_hit(4'b0010);
    n_total++; if (bus.shot_active !== 4'b0000) $display("FAIL hit_async_clear got %b want 0000", bus.shot_active); else n_pass++;
  endtask

  task automatic test_pixel();
    do_reset();
    bus.player_x = 10'd100;
    launch_and_settle();
    bus.DrawX = 10'd101; bus.DrawY = 10'd405; #1;
    n_total++; if (bus.is_shot !== 1'b1) $display("FAIL pix_101_405 got %b want 1", bus.is_shot); else n_pass++;
    bus.DrawX = 10'd102; #1;
    n_total++; if (bus.is_shot !== 1'b0) $display("FAIL pix_102_405 got %b want 0", bus.is_shot); else n_pass++;
    bus.DrawX = 10'd100; bus.DrawY = 10'd400; #1;
    n_total++; if (bus.is_shot !== 1'b1) $display("FAIL pix_100_400 got %b want 1", bus.is_shot); else n_pass++;
    bus.DrawX = 10'd99; #1;
    n_total++; if (bus.is_shot !== 1'b0) $display("FAIL pix_99_400 got %b want 0", bus.is_shot); else n_pass++;
    bus.DrawX = 10'd100; bus.DrawY = 10'd399; #1;
    n_total++; if (bus.is_shot !== 1'b0) $display("FAIL pix_100_399 got %b want 0", bus.is_shot); else n_pass++;
  endtask

  task automatic test_pool_full();
    do_reset();
    for (int k = 0; k < 4; k++) launch_and_settle();
    n_total++; if (bus.shot_active !== 4'b1111) $display("FAIL pool_active got %b want 1111", bus.shot_active); else n_pass++;
    bus.keycode = 8'd44;
    do_frame();
    n_total++; if (bus.shots_fired !== 8'd4) $display("FAIL pool_drop got %0d want 4", bus.shots_fired); else n_pass++;
    pulse_hit(4'b0100);
    n_total++; if (bus.shot_active !== 4'b1011) $display("FAIL pool_hit2 got %b want 1011", bus.shot_active); else n_pass++;
    do_frame();
    bus.keycode = 8'd0;
    n_total++; if (bus.shot_active !== 4'b1111) $display("FAIL pool_refill got %b want 1111", bus.shot_active); else n_pass++;
    n_total++; if (bus.shots_fired !== 8'd5) $display("FAIL pool_refill_cnt got %0d want 5", bus.shots_fired); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    launch_and_settle();
    bus.keycode = 8'd44;
    @(negedge Clk) bus.frame_clk = 1'b1;
    @(negedge Clk) begin bus.frame_clk = 1'b0; Reset = 1'b1; end
    #1;
    n_total++; if (bus.shots_fired !== 8'd0) $display("FAIL midreset_fired got %0d want 0", bus.shots_fired); else n_pass++;
    n_total++; if (bus.shot_active !== 4'b0000) $display("FAIL midreset_active got %b want 0000", bus.shot_active); else n_pass++;
    @(negedge Clk) Reset = 1'b0;
    bus.keycode = 8'd0;
    repeat (4) @(negedge Clk);
    n_total++; if (bus.shot_active !== 4'b0000) $display("FAIL midreset_nolaunch got %b want 0000", bus.shot_active); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 256; k++) begin
      launch_and_settle();
      pulse_hit(4'b1111);
      if (k == 254) begin
        n_total++; if (bus.shots_fired !== 8'd255) $display("FAIL wrap_255 got %0d want 255", bus.shots_fired); else n_pass++;
      end
    end
    n_total++; if (bus.shots_fired !== 8'd0) $display("FAIL wrap_0 got %0d want 0", bus.shots_fired); else n_pass++;
  endtask

  initial begin
    Reset = 1'b1;
    hit2 = 4'b0000;
    bus.frame_clk = 1'b0;
    bus.keycode = 8'd0;
    bus.player_x = 10'd100;
    bus.hit = 4'b0000;
    bus.DrawX = 10'd0;
    bus.DrawY = 10'd0;
    test_reset();
    test_single_shot();
`ifdef SHOT_AUTOFIRE_EN
    test_autofire();
`else
    test_hold();
`endif
    test_hit_launch();
    test_pixel();
    test_pool_full();
    test_reset_midflight();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
